// File: rtl/sensor_scan_scheduler_pkg.sv
// rtl/sensor_scan_scheduler_pkg.sv - shared healthcare channel codes, scan states and alarm priority
package sensor_scan_scheduler_pkg;

    localparam logic [1:0] CH_PRESSURE = 2'd0;
    localparam logic [1:0] CH_BLOOD    = 2'd1;
    localparam logic [1:0] CH_FALL     = 2'd2;
    localparam logic [1:0] CH_TEMP     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } scan_state_t;

    // Slot 0 (LSBs) is the most urgent channel.
    localparam logic [7:0] PRIO_ORDER = {CH_BLOOD, CH_TEMP, CH_PRESSURE, CH_FALL};

    // Returns {found, channel} of the most urgent set bit in cand.
    function automatic logic [2:0] pick_alarm(input logic [3:0] cand);
        logic [2:0] w_res;
        w_res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (cand[PRIO_ORDER[2*i +: 2]]) begin
                w_res = {1'b1, PRIO_ORDER[2*i +: 2]};
            end
        end
        return w_res;
    endfunction

endpackage

// File: rtl/sensor_scan_scheduler_confirm.sv
// rtl/sensor_scan_scheduler_confirm.sv - one channel's saturating confirm counter with pending/reported bits
module alarm_confirm_counter
    import sensor_scan_scheduler_pkg::*;
#(
    parameter int CONFIRM_COUNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample_en,
    input  logic i_flag,
    input  logic i_clear,
    input  logic i_report,
    output logic o_pending,
    output logic o_reported
);

    localparam logic [3:0] CONFIRM = 4'(CONFIRM_COUNT);

    logic [3:0] r_count;
    logic       r_pending;
    logic       r_reported;
    logic [3:0] w_count_inc;

    assign w_count_inc = (r_count >= CONFIRM) ? CONFIRM : r_count + 4'd1;

    // Clear is checked first so it beats a confirm landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 4'd0;
            r_pending  <= 1'b0;
            r_reported <= 1'b0;
        end else if (i_clear) begin
            r_count    <= 4'd0;
            r_pending  <= 1'b0;
            r_reported <= 1'b0;
        end else begin
            if (i_sample_en) begin
                if (!i_flag) begin
                    r_count <= 4'd0;
                end else begin
                    r_count <= w_count_inc;
                    if (w_count_inc == CONFIRM) begin
                        r_pending <= 1'b1;
                    end
                end
            end
            if (i_report) begin
                r_reported <= 1'b1;
            end
        end
    end

    assign o_pending  = r_pending;
    assign o_reported = r_reported;

endmodule

// File: rtl/sensor_scan_scheduler.sv
// rtl/sensor_scan_scheduler.sv - round-robin detector scan, debounce and prioritised nurse-call handshake
module sensor_scan_scheduler
    import sensor_scan_scheduler_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 4,
    parameter int CONFIRM_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       presureAbnormality,
    input  logic       bloodAbnormality,
    input  logic       fallDetected,
    input  logic       temperatureAbnormality,
    input  logic [3:0] clearAlarm,
    input  logic       alarmAck,
    output logic [1:0] sensorSelect,
    output logic       sampleStrobe,
    output logic [3:0] alarmPending,
    output logic       alarmValid,
    output logic [1:0] alarmCode
);

    localparam int CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD - 1) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SAMPLE_PERIOD - 2);

    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic [CW-1:0] r_settle_cnt;
    logic [CW-1:0] w_settle_nxt;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_nxt;
    logic          w_strobe;

    logic [3:0]    w_flags;
    logic [3:0]    w_pending;
    logic [3:0]    w_reported;
    logic [3:0]    w_candidates;
    logic [2:0]    w_pick;
    logic          w_ack_fire;
    logic          r_valid;
    logic [1:0]    r_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_sel        <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_sel        <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_sel_nxt    = r_sel;
        w_strobe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                    w_sel_nxt    = 2'd0;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_settle_nxt = r_settle_cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_strobe     = 1'b1;
                w_state_nxt  = ST_SETTLE;
                w_settle_nxt = '0;
                w_sel_nxt    = r_sel + 2'd1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Dropping enable abandons the slot; the next enable restarts at channel 0.
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_flags    = {temperatureAbnormality, fallDetected, bloodAbnormality, presureAbnormality};
    assign w_ack_fire = r_valid & alarmAck;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        alarm_confirm_counter #(
            .CONFIRM_COUNT (CONFIRM_COUNT)
        ) u_confirm (
            .clk         (clk),
            .rst         (rst),
            .i_sample_en (w_strobe && (r_sel == 2'(g))),
            .i_flag      (w_flags[g]),
            .i_clear     (clearAlarm[g]),
            .i_report    (w_ack_fire && (r_code == 2'(g))),
            .o_pending   (w_pending[g]),
            .o_reported  (w_reported[g])
        );
    end

    assign w_candidates = w_pending & ~w_reported;
    assign w_pick       = pick_alarm(w_candidates);

    // A presented code is frozen until acked or cleared; re-arbitration waits a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= 2'd0;
        end else if (r_valid) begin
            if (alarmAck || clearAlarm[r_code]) begin
                r_valid <= 1'b0;
            end
        end else if (w_pick[2]) begin
            r_valid <= 1'b1;
            r_code  <= w_pick[1:0];
        end
    end

    assign sensorSelect = r_sel;
    assign sampleStrobe = w_strobe;
    assign alarmPending = w_pending;
    assign alarmValid   = r_valid;
    assign alarmCode    = r_code;

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// tb/tb_sensor_scan_scheduler.sv - scoreboard bench for sensor_scan_scheduler
module tb_sensor_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic       fallDetected;
    logic       temperatureAbnormality;
    logic [3:0] clearAlarm;
    logic       alarmAck;
    logic [1:0] sensorSelect;
    logic       sampleStrobe;
    logic [3:0] alarmPending;
    logic       alarmValid;
    logic [1:0] alarmCode;

    sensor_scan_scheduler #(
        .SAMPLE_PERIOD (4),
        .CONFIRM_COUNT (3)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable                 (enable),
        .presureAbnormality     (presureAbnormality),
        .bloodAbnormality       (bloodAbnormality),
        .fallDetected           (fallDetected),
        .temperatureAbnormality (temperatureAbnormality),
        .clearAlarm             (clearAlarm),
        .alarmAck               (alarmAck),
        .sensorSelect           (sensorSelect),
        .sampleStrobe           (sampleStrobe),
        .alarmPending           (alarmPending),
        .alarmValid             (alarmValid),
        .alarmCode              (alarmCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t strobe_q[$];
    exp_t alarm_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_n   = 0;
    int   t0       = 0;
    logic prev_valid = 1'b0;
    logic [1:0] prev_code = 2'd0;

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    // Cycle n of the current run is the period closed by edge t0+n; observed at the negedge before it.
    task automatic wait_cyc(input int c);
        while (edge_n + 1 < c) @(negedge clk);
    endtask

    task automatic wait_rel(input int n);
        wait_cyc(t0 + n);
    endtask

    task automatic start_scan();
        enable = 1'b1;
        t0     = edge_n + 1;
    endtask

    task automatic push_strobes(input int n);
        for (int k = 0; k < n; k++) strobe_q.push_back('{t0 + 4 * (k + 1), k % 4});
    endtask

    task automatic push_alarm(input int rel, input int code);
        alarm_q.push_back('{t0 + rel, code});
    endtask

    // Monitor: every strobe and every new alarm presentation must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   cyc_now;
        cyc_now = edge_n + 1;
        if (!rst) begin
            if (sampleStrobe) begin
                if (strobe_q.size() == 0) begin
                    check("unexpected_strobe_cycle", cyc_now, -1);
                end else begin
                    e = strobe_q.pop_front();
                    check("strobe_cycle", cyc_now, e.cyc);
                    check("strobe_channel", int'(sensorSelect), e.val);
                end
            end
            if (alarmValid && !prev_valid) begin
                if (alarm_q.size() == 0) begin
                    check("unexpected_alarm_cycle", cyc_now, -1);
                end else begin
                    e = alarm_q.pop_front();
                    check("alarm_cycle", cyc_now, e.cyc);
                    check("alarm_code", int'(alarmCode), e.val);
                end
            end
            if (alarmValid && prev_valid) check("alarm_code_held", int'(alarmCode), int'(prev_code));
        end
        prev_valid = alarmValid;
        prev_code  = alarmCode;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},     int'(sensorSelect), 0);
        check({tag, "_strobe"},  int'(sampleStrobe), 0);
        check({tag, "_pending"}, int'(alarmPending), 0);
        check({tag, "_valid"},   int'(alarmValid),   0);
        check({tag, "_code"},    int'(alarmCode),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; clearAlarm = 4'd0; alarmAck = 1'b0;
        presureAbnormality = 1'b0; bloodAbnormality = 1'b0;
        fallDetected = 1'b0; temperatureAbnormality = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_init");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fall confirm plus blood debounce: blood 1,1,0,1,1 never reaches three in a row.
        fallDetected = 1'b1; bloodAbnormality = 1'b1;
        start_scan();
        push_strobes(18);
        push_alarm(46, 2);
        wait_rel(30); bloodAbnormality = 1'b0;
        wait_rel(44); check("fall_pending_c44", int'(alarmPending), 4'b0000);
        wait_rel(45); check("fall_pending_c45", int'(alarmPending), 4'b0100);
        wait_rel(46); check("fall_valid_c46", int'(alarmValid), 1);
        wait_rel(50); bloodAbnormality = 1'b1;
        wait_rel(73); check("blood_never_pending", int'(alarmPending), 4'b0100);
        enable = 1'b0; bloodAbnormality = 1'b0;

        // Priority: pressure confirms under a presented fall alarm.
        wait_rel(76);
        presureAbnormality = 1'b1;
        start_scan();
        push_strobes(10);
        wait_rel(37); check("prio_pending", int'(alarmPending), 4'b0101);
        wait_rel(41); check("prio_valid_held", int'(alarmValid), 1);
        check("prio_code_held", int'(alarmCode), 2);
        enable = 1'b0; presureAbnormality = 1'b0;
        wait_rel(44); alarmAck = 1'b1; push_alarm(46, 0);
        wait_rel(45); alarmAck = 1'b0; check("ack1_valid_drop", int'(alarmValid), 0);
        wait_rel(48); alarmAck = 1'b1;
        wait_rel(49); alarmAck = 1'b0; check("ack2_valid_drop", int'(alarmValid), 0);
        wait_rel(50); alarmAck = 1'b1;
        wait_rel(51); alarmAck = 1'b0;
        wait_rel(52); check("ack_idle_valid", int'(alarmValid), 0);
        check("ack_idle_pending", int'(alarmPending), 4'b0101);

        // Clear ch2, reconfirm, then clear it while presented.
        clearAlarm = 4'b0100;
        wait_rel(53); clearAlarm = 4'b0000;
        check("clear_idle_pending", int'(alarmPending), 4'b0001);
        wait_rel(55);
        start_scan();
        push_strobes(24);
        push_alarm(46, 2);
        wait_rel(45); check("reconfirm_pending", int'(alarmPending), 4'b0101);
        wait_rel(50); clearAlarm = 4'b0100;
        wait_rel(51); clearAlarm = 4'b0000;
        check("clear_presented_valid", int'(alarmValid), 0);
        check("clear_presented_pending", int'(alarmPending), 4'b0001);
        push_alarm(94, 2);
        wait_rel(92); check("reclear_pending_c92", int'(alarmPending), 4'b0001);
        wait_rel(93); check("reclear_pending_c93", int'(alarmPending), 4'b0101);
        wait_rel(97); enable = 1'b0; fallDetected = 1'b0;
        wait_rel(98); alarmAck = 1'b1;
        wait_rel(99); alarmAck = 1'b0;

        // Disable mid-SETTLE: ch0 count survives the pause.
        clearAlarm = 4'b0001;
        wait_rel(100); clearAlarm = 4'b0000;
        check("pre_disable_pending", int'(alarmPending), 4'b0100);
        presureAbnormality = 1'b1;
        wait_rel(102);
        start_scan();
        push_strobes(1);
        wait_rel(6); enable = 1'b0;
        wait_rel(12); check("disable_pending", int'(alarmPending), 4'b0100);
        start_scan();
        push_strobes(5);
        push_alarm(22, 0);
        wait_rel(21); check("resume_pending", int'(alarmPending), 4'b0101);
        wait_rel(23); enable = 1'b0;
        check("resume_valid", int'(alarmValid), 1);
        check("resume_code", int'(alarmCode), 0);

        // Async reset mid-SETTLE with an alarm presented.
        wait_rel(26);
        start_scan();
        push_strobes(2);
        wait_rel(10);
        check("pre_reset_sel", int'(sensorSelect), 2);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid");
        @(negedge clk); @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_pending", int'(alarmPending), 0);
        check("post_reset_valid", int'(alarmValid), 0);

        check("strobe_q_left", strobe_q.size(), 0);
        check("alarm_q_left", alarm_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sensor_scan_scheduler.md
# sensor_scan_scheduler

- Time-multiplexes the four abnormality detectors of the first-phase healthcare system: pressure, blood, fall and temperature.
- Walks a round-robin scan over them, driving the shared sensor-input mux, and samples each detector flag after a settling window.
- Debounces each flag over consecutive scans and latches confirmed alarms.
- Presents confirmed alarms one at a time, by priority, on a valid/ack handshake to the nurse-call unit.

## Interface
- SAMPLE_PERIOD, 4: cycles per channel slot (SAMPLE_PERIOD-1 settle + 1 sample); legal range ≥ 2.
- CONFIRM_COUNT, 3: consecutive abnormal samples required to confirm; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable.
- presureAbnormality  in  1  pressure detector flag (channel 0).
- bloodAbnormality  in  1  blood detector flag (channel 1).
- fallDetected  in  1  fall detector flag (channel 2).
- temperatureAbnormality  in  1  temperature detector flag (channel 3).
- clearAlarm  in  4  per-channel clear of latched alarm, counter and reported flag.
- alarmAck  in  1  nurse-call acknowledge.
- sensorSelect  out  2  channel currently routed through the sensor mux.
- sampleStrobe  out  1  one-cycle pulse marking the sampling cycle.
- alarmPending  out  4  latched confirmed alarms, indexed by channel.
- alarmValid  out  1  an unreported confirmed alarm is presented.
- alarmCode  out  2  channel of the presented alarm.

## Operation
- **Reset values** (all outputs, all state): FSM=IDLE, sensorSelect=0, sampleStrobe=0, alarmPending=0, alarmValid=0, alarmCode=0. Per-channel counters and reported bits are 0.
- **FSM states:** IDLE, SETTLE, SAMPLE.
- **IDLE:**
  - enable=1 → SETTLE with sensorSelect=0 and the settle counter cleared.
- **SETTLE:**
  - Lasts SAMPLE_PERIOD-1 cycles, then → SAMPLE.
- **SAMPLE:**
  - Lasts one cycle; sampleStrobe=1.
  - At the closing edge the flag of channel sensorSelect updates that channel's counter.
  - The FSM then → SETTLE with sensorSelect+1, wrapping 3→0.
- **Disable:** enable=0 in any state → IDLE at the next edge.
  - No strobe is issued for the aborted slot.
  - Counters, alarmPending and the handshake are retained.
  - Re-enabling always restarts the scan at channel 0.
- **Confirm counters:**
  - Each channel's counter is 4 bits, saturating at CONFIRM_COUNT.
  - Sampled flag 0 → counter=0.
  - Sampled flag 1 → counter+1, saturating.
  - When the new value equals CONFIRM_COUNT, alarmPending[ch] is set at the same edge.
- **Clear:** clearAlarm[i]=1 zeroes counter[i], alarmPending[i] and reported[i] at the next edge.
  - Clear wins over a simultaneous confirm on the same channel.
- **Candidates:** a channel is a candidate when alarmPending & ~reported is set for it.
  - Priority order: fall(2) > pressure(0) > temperature(3) > blood(1).
- **Handshake:**
  - alarmValid and alarmCode are registered.
  - When idle and any candidate exists, the next edge sets alarmValid=1 and alarmCode=highest-priority candidate.
  - While alarmValid=1 without ack, alarmCode is held even if a higher-priority alarm confirms.
  - alarmValid&alarmAck at an edge sets reported[alarmCode] and drops alarmValid for at least one cycle.
  - alarmAck while alarmValid=0 is ignored.
  - Clearing the presented channel while alarmValid=1 drops alarmValid at the next edge; no ack is required.

## Timing
- Slot length is SAMPLE_PERIOD cycles; a full scan is 4·SAMPLE_PERIOD cycles.
- Take cycle 0 as the first edge with enable=1. Channel c is sampled in cycle SAMPLE_PERIOD·(c+1), then every 4·SAMPLE_PERIOD cycles.
- alarmPending is visible the cycle after the confirming strobe; alarmValid follows one cycle later.
- Async rst mid-slot or mid-handshake forces all reset values immediately. Scanning resumes only after rst is low and enable is sampled high.

## Structure
- Shared healthcare package holds:
  - channel code constants CH_PRESSURE=0, CH_BLOOD=1, CH_FALL=2, CH_TEMP=3;
  - FSM state encoding;
  - the alarm priority order.
- Sub-module alarm_confirm_counter holds one channel's saturating counter plus its pending and reported bits, with clear precedence. It is instantiated four times.
- The scan FSM and the priority/handshake logic stay in the top module.

## Test plan
All scenarios use default parameters.
- **Reset:** assert rst in cycle 10 mid-SETTLE → all outputs 0 within the same cycle; no strobe until after rst releases and enable is sampled high.
- **Fall confirm:** fallDetected held 1 → channel 2 strobes in cycles 12, 28, 44; alarmPending=4'b0100 from cycle 45; alarmValid=1 with alarmCode=2 from cycle 46.
- **Debounce:** bloodAbnormality 1 for the samples in cycles 8 and 24, 0 for cycle 40 → counter back to 0; alarmPending[1] never set.
- **Priority:** pressure and fall confirmed; hold alarmAck=0 → alarmCode=2, held stable; ack → alarmValid=0 for one cycle, then alarmCode=0 with alarmValid=1; ack → alarmValid stays 0.
- **Clear while presented:** clearAlarm=4'b0100 while code 2 is presented → alarmValid=0 and alarmPending[2]=0 at the next edge. With fallDetected still 1, code 2 is re-presented after three further channel-2 samples.
- **Disable mid-SETTLE:** enable=0 in cycle 6 → IDLE next cycle; no strobe for channel 1. Re-enable → first strobe on channel 0 after SAMPLE_PERIOD cycles; counters unchanged.
